// File: rtl/cache_line_refill_ctrl.sv
// Miss handler: optional ascending writeback of the dirty victim line, then line fetch into the fill port.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the fetch at the missed word and wraps.
module cache_line_refill_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int OFFSET_WIDTH  = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     miss_req,
    input  logic [ADDRESS_WIDTH-1:0] miss_addr,
    input  logic                     wb_dirty,
    input  logic [ADDRESS_WIDTH-1:0] wb_addr,
    output logic [OFFSET_WIDTH-1:0]  wb_idx,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     fill_we,
    output logic [OFFSET_WIDTH-1:0]  fill_idx,
    output logic [DATA_WIDTH-1:0]    fill_data,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    localparam int BASE_W = ADDRESS_WIDTH - OFFSET_WIDTH;
    localparam int WORDS  = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH:0] LAST = (OFFSET_WIDTH+1)'(WORDS - 1);
    localparam logic [OFFSET_WIDTH:0] ONE  = (OFFSET_WIDTH+1)'(1);

    typedef enum logic [2:0] {IDLE, WB_REQ, RD_REQ, RD_WAIT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [OFFSET_WIDTH:0]   cnt, cnt_nxt;
    logic [BASE_W-1:0]       miss_base, vict_base;
    logic [OFFSET_WIDTH-1:0] start_idx, start_nxt, rd_idx;
    logic                    unused_ok;

    assign unused_ok = ^{wb_addr[OFFSET_WIDTH-1:0], miss_addr[OFFSET_WIDTH-1:0]};
    assign rd_idx    = start_idx + cnt[OFFSET_WIDTH-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_nxt = miss_addr[OFFSET_WIDTH-1:0];
`else
    assign start_nxt = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            miss_base <= '0;
            vict_base <= '0;
            start_idx <= '0;
            fill_we   <= 1'b0;
            fill_idx  <= '0;
            fill_data <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            fill_we <= 1'b0;
            if (state == IDLE && miss_req) begin
                miss_base <= miss_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                vict_base <= wb_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                start_idx <= start_nxt;
            end
            if (state == RD_WAIT && mem_rvalid) begin
                fill_we   <= 1'b1;
                fill_idx  <= rd_idx;
                fill_data <= mem_rdata;
            end
        end
    end

    // Request outputs depend only on state and registers, so they stay put until accepted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b1;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wb_idx    = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (miss_req) begin
                    cnt_nxt   = '0;
                    state_nxt = wb_dirty ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vict_base, cnt[OFFSET_WIDTH-1:0]};
                mem_wdata = wb_data;
                wb_idx    = cnt[OFFSET_WIDTH-1:0];
                if (mem_ready) begin
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = RD_REQ;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
            end
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {miss_base, rd_idx};
                if (mem_ready) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    cnt_nxt   = cnt + ONE;
                    state_nxt = (cnt == LAST) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_line_refill_ctrl.sv
// Directed + randomized bench: a memory responder records transactions; expected sequences come from line-level rules.
module tb_cache_line_refill_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OW = 2;
    localparam int WORDS = 4;

    logic          clk = 0;
    logic          reset_n = 0;
    logic          miss_req = 0;
    logic [AW-1:0] miss_addr = '0;
    logic          wb_dirty = 0;
    logic [AW-1:0] wb_addr = '0;
    logic [OW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic          fill_we;
    logic [OW-1:0] fill_idx;
    logic [DW-1:0] fill_data;
    logic          busy, done, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 0;
    logic          mem_rvalid = 0;
    logic [DW-1:0] mem_rdata = '0;

    cache_line_refill_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW)) dut (
        .clk(clk), .reset_n(reset_n), .miss_req(miss_req), .miss_addr(miss_addr),
        .wb_dirty(wb_dirty), .wb_addr(wb_addr), .wb_idx(wb_idx), .wb_data(wb_data),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] victim [WORDS];
    assign wb_data = victim[wb_idx];

    logic [63:0] wr_q[$], exp_wr[$];
    logic [63:0] rd_q[$], exp_rd[$];
    logic [63:0] fill_q[$], exp_fill[$];
    int  done_cnt = 0;
    int  busy_cycles = 0;
    bit  fast = 0;
    bit  hold = 0;
    bit  rd_pend = 0;
    int  rd_delay = 0;
    logic [AW-1:0] rd_addr = '0;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory responder and observer; everything changes at negedge, handshakes complete at posedge.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ready  = 0;
            mem_rvalid = 0;
            rd_pend    = 0;
        end else begin
            if (fill_we) fill_q.push_back(64'({fill_idx, fill_data}));
            if (done) done_cnt++;
            if (busy) busy_cycles++;
            mem_rvalid = 0;
            if (rd_pend) begin
                if (rd_delay == 0) begin
                    mem_rvalid = 1;
                    mem_rdata  = mem_fn(rd_addr);
                    rd_pend    = 0;
                end else begin
                    rd_delay--;
                end
            end
            if (hold) mem_ready = 0;
            else      mem_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    wr_q.push_back({mem_addr, mem_wdata});
                end else begin
                    rd_q.push_back(64'(mem_addr));
                    rd_pend  = 1;
                    rd_addr  = mem_addr;
                    rd_delay = fast ? 0 : int'($urandom_range(0, 3));
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 0);
        chk({tag, " done"}, 64'(done), 0);
        chk({tag, " fill_we"}, 64'(fill_we), 0);
        chk({tag, " fill_idx"}, 64'(fill_idx), 0);
        chk({tag, " fill_data"}, 64'(fill_data), 0);
        chk({tag, " mem_req"}, 64'(mem_req), 0);
        chk({tag, " mem_we"}, 64'(mem_we), 0);
        chk({tag, " mem_addr"}, 64'(mem_addr), 0);
        chk({tag, " mem_wdata"}, 64'(mem_wdata), 0);
        chk({tag, " wb_idx"}, 64'(wb_idx), 0);
    endtask

    // Called at posedge+2; returns at posedge+2 one cycle after the miss is accepted.
    task automatic start_miss(input logic [AW-1:0] addr, input bit dirty, input logic [AW-1:0] vaddr);
        logic [OW-1:0] s;
        logic [AW-1:0] a;
        for (int i = 0; i < WORDS; i++) victim[i] = $urandom;
        exp_wr.delete(); exp_rd.delete(); exp_fill.delete();
        wr_q.delete(); rd_q.delete(); fill_q.delete();
        if (dirty)
            for (int i = 0; i < WORDS; i++)
                exp_wr.push_back({{vaddr[AW-1:OW], OW'(i)}, victim[i]});
`ifdef CRITICAL_WORD_FIRST_EN
        s = addr[OW-1:0];
`else
        s = '0;
`endif
        for (int i = 0; i < WORDS; i++) begin
            a = {addr[AW-1:OW], OW'((int'(s) + i) % WORDS)};
            exp_rd.push_back(64'(a));
            exp_fill.push_back(64'({a[OW-1:0], mem_fn(a)}));
        end
        done_cnt = 0;
        busy_cycles = 0;
        miss_req = 1; miss_addr = addr; wb_dirty = dirty; wb_addr = vaddr;
        @(posedge clk); #2;
        miss_req = 0; miss_addr = $urandom; wb_addr = $urandom; wb_dirty = 1'($urandom);
        chk("busy_after_accept", 64'(busy), 1);
    endtask

    task automatic check_miss(input string tag, input int exp_busy);
        for (int i = 0; i < 2000 && done_cnt == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        chk({tag, " done_count"}, 64'(done_cnt), 1);
        chk({tag, " busy_idle"}, 64'(busy), 0);
        chk({tag, " n_writes"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        chk({tag, " n_reads"}, 64'(rd_q.size()), 64'(exp_rd.size()));
        chk({tag, " n_fills"}, 64'(fill_q.size()), 64'(exp_fill.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) chk({tag, " write"}, wr_q[i], exp_wr[i]);
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) chk({tag, " read"}, rd_q[i], exp_rd[i]);
        for (int i = 0; i < exp_fill.size() && i < fill_q.size(); i++) chk({tag, " fill"}, fill_q[i], exp_fill[i]);
        if (exp_busy > 0) chk({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    endtask

    initial begin
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        for (int i = 0; i < WORDS; i++) victim[i] = '0;
        #12;
        chk_zero("reset");
        @(posedge clk); #2;
        reset_n = 1;
        @(posedge clk); #2;

        // Clean miss, fast memory: reads only, ascending (or critical-word-first) order.
        fast = 1;
        start_miss(32'h0000_0104, 0, 32'h0000_0800);
        check_miss("clean", 2 * WORDS + 1);

        // Dirty miss: writeback of all words, then the fetch.
        start_miss(32'h0000_0104, 1, 32'h0000_0200);
        check_miss("dirty", 3 * WORDS + 1);

        // Miss inside the line: order depends on the build macro.
        start_miss(32'h0000_0106, 0, 32'h0000_0000);
        check_miss("cwf", 2 * WORDS + 1);

        // Memory stalls: request must hold steady while not accepted.
        fast = 0;
        hold = 1;
        start_miss(32'h0000_0305, 1, 32'h0000_0400);
        a0 = mem_addr;
        d0 = mem_wdata;
        chk("stall mem_req", 64'(mem_req), 1);
        chk("stall mem_we", 64'(mem_we), 1);
        chk("stall first addr", 64'(a0), 64'h400);
        chk("stall first data", 64'(d0), 64'(victim[0]));
        repeat (5) begin
            @(posedge clk); #2;
            chk("stall req stable", 64'(mem_req), 1);
            chk("stall addr stable", 64'(mem_addr), 64'(a0));
            chk("stall wdata stable", 64'(mem_wdata), 64'(d0));
        end
        hold = 0;
        check_miss("stall", 0);

        // A second miss while busy is dropped.
        start_miss(32'h0000_0a02, 1, 32'h0000_0b00);
        repeat (3) @(posedge clk);
        #2;
        miss_req = 1; miss_addr = 32'h0000_0c00; wb_dirty = 1; wb_addr = 32'h0000_0d00;
        @(posedge clk); #2;
        miss_req = 0;
        check_miss("ignored", 0);

        // Reset while waiting for read data.
        fast = 1;
        start_miss(32'h0000_0300, 0, 32'h0000_0000);
        for (int i = 0; i < 50 && !(busy && !mem_req && !done); i++) begin
            @(posedge clk); #2;
        end
        chk("in_rd_wait", 64'(busy && !mem_req && !done), 1);
        reset_n = 0;
        #1;
        chk_zero("midreset");
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1;
        repeat (4) @(posedge clk);
        #2;
        chk("midreset no done", 64'(done_cnt), 0);
        chk("midreset idle", 64'(busy), 0);
        start_miss(32'h0000_0507, 1, 32'h0000_0600);
        check_miss("after_reset", 3 * WORDS + 1);

        // Randomized misses against random memory timing.
        fast = 0;
        for (int n = 0; n < 8; n++) begin
            start_miss($urandom, 1'($urandom), $urandom);
            check_miss("random", 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
